// File: rtl/alu_issue_stage_pkg.sv
// Shared encodings for the ALU issue stage: ALUOp codes, instruction classes and funct3 values.
package alu_issue_stage_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    CLS_LDST = 2'b00,
    CLS_BR   = 2'b01,
    CLS_R    = 2'b10,
    CLS_I    = 2'b11
  } alu_class_e;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

endpackage

// File: rtl/alu_issue_stage_alu_control.sv
// Combinational ALU control: maps instruction class and funct fields to ALUOp plus an illegal flag.
module alu_issue_stage_alu_control
  import alu_issue_stage_pkg::*;
(
  input  logic [1:0] i_alu_class,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output logic [3:0] o_alu_op,
  output logic       o_illegal
);

  always_comb begin
    o_alu_op  = ALU_ADD;
    o_illegal = 1'b0;
    case (i_alu_class)
      CLS_LDST: o_alu_op = ALU_ADD;
      CLS_BR:   o_alu_op = ALU_SUB;
      CLS_R, CLS_I: begin
        case (i_funct3)
          // funct7[5] selects SUB only for register-register ops
          F3_ADD_SUB: o_alu_op = (i_alu_class == CLS_R && i_funct7_5) ? ALU_SUB : ALU_ADD;
          F3_AND:     o_alu_op = ALU_AND;
          F3_OR:      o_alu_op = ALU_OR;
          default: begin
            o_alu_op  = ALU_ADD;
            o_illegal = 1'b1;
          end
        endcase
      end
      default: o_alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage feeding the ALU: operand resolution, ALUOp decode, load-use/backpressure stalls.
// Define ALU_ISSUE_FWD_EN to enable MEM/WB forwarding; otherwise any pending writer stalls decode.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_dec_valid,
  output logic              o_dec_ready,
  input  logic [REG_AW-1:0] i_dec_rs1,
  input  logic [REG_AW-1:0] i_dec_rs2,
  input  logic [REG_AW-1:0] i_dec_rd,
  input  logic [XLEN-1:0]   i_dec_rs1_data,
  input  logic [XLEN-1:0]   i_dec_rs2_data,
  input  logic [XLEN-1:0]   i_dec_imm,
  input  logic              i_dec_alu_src,
  input  logic [1:0]        i_dec_alu_class,
  input  logic [2:0]        i_dec_funct3,
  input  logic              i_dec_funct7_5,
  input  logic              i_dec_is_load,
  input  logic              i_flush,
  input  logic              i_mem_fwd_valid,
  input  logic [REG_AW-1:0] i_mem_fwd_rd,
  input  logic [XLEN-1:0]   i_mem_fwd_data,
  input  logic              i_wb_fwd_valid,
  input  logic [REG_AW-1:0] i_wb_fwd_rd,
  input  logic [XLEN-1:0]   i_wb_fwd_data,
  input  logic              i_ex_ready,
  output logic              o_ex_valid,
  output logic [XLEN-1:0]   o_a,
  output logic [XLEN-1:0]   o_b,
  output logic [3:0]        o_alu_op,
  output logic [XLEN-1:0]   o_ex_store_data,
  output logic [REG_AW-1:0] o_ex_rd,
  output logic              o_ex_is_load,
  output logic              o_ex_illegal
);

  logic              r_ex_valid;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [3:0]        r_alu_op;
  logic [XLEN-1:0]   r_store_data;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_is_load;
  logic              r_ex_illegal;

  logic              w_adv;
  logic              w_hazard;
  logic              w_load_use;
  logic              w_xfer;
  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;
  logic [3:0]        w_alu_op;
  logic              w_illegal;

  assign w_adv      = ~r_ex_valid | i_ex_ready;
  assign w_load_use = r_ex_valid & r_ex_is_load & (r_ex_rd != '0) &
                      ((r_ex_rd == i_dec_rs1) | (r_ex_rd == i_dec_rs2));

`ifdef ALU_ISSUE_FWD_EN
  assign w_hazard = w_load_use;

  // MEM result is younger than WB, so it wins when both target the same register
  always_comb begin
    w_op1 = i_dec_rs1_data;
    if (i_dec_rs1 == '0)                                       w_op1 = '0;
    else if (i_mem_fwd_valid && (i_mem_fwd_rd == i_dec_rs1))   w_op1 = i_mem_fwd_data;
    else if (i_wb_fwd_valid && (i_wb_fwd_rd == i_dec_rs1))     w_op1 = i_wb_fwd_data;
  end

  always_comb begin
    w_op2 = i_dec_rs2_data;
    if (i_dec_rs2 == '0)                                       w_op2 = '0;
    else if (i_mem_fwd_valid && (i_mem_fwd_rd == i_dec_rs2))   w_op2 = i_mem_fwd_data;
    else if (i_wb_fwd_valid && (i_wb_fwd_rd == i_dec_rs2))     w_op2 = i_wb_fwd_data;
  end
`else
  logic w_dep1;
  logic w_dep2;
  logic w_unused_fwd;

  // Without bypass paths, any in-flight writer of a source must retire before issue
  assign w_dep1 = (i_dec_rs1 != '0) &
                  ((i_mem_fwd_valid & (i_mem_fwd_rd == i_dec_rs1)) |
                   (i_wb_fwd_valid & (i_wb_fwd_rd == i_dec_rs1)) |
                   (r_ex_valid & (r_ex_rd == i_dec_rs1)));
  assign w_dep2 = (i_dec_rs2 != '0) &
                  ((i_mem_fwd_valid & (i_mem_fwd_rd == i_dec_rs2)) |
                   (i_wb_fwd_valid & (i_wb_fwd_rd == i_dec_rs2)) |
                   (r_ex_valid & (r_ex_rd == i_dec_rs2)));
  assign w_hazard     = w_load_use | w_dep1 | w_dep2;
  assign w_op1        = (i_dec_rs1 == '0) ? '0 : i_dec_rs1_data;
  assign w_op2        = (i_dec_rs2 == '0) ? '0 : i_dec_rs2_data;
  assign w_unused_fwd = ^{i_mem_fwd_data, i_wb_fwd_data};
`endif

  assign o_dec_ready = i_flush | (w_adv & ~w_hazard);
  assign w_xfer      = i_dec_valid & o_dec_ready & ~i_flush;

  alu_issue_stage_alu_control u_alu_control (
    .i_alu_class (i_dec_alu_class),
    .i_funct3    (i_dec_funct3),
    .i_funct7_5  (i_dec_funct7_5),
    .o_alu_op    (w_alu_op),
    .o_illegal   (w_illegal)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ex_valid   <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_alu_op     <= ALU_AND;
      r_store_data <= '0;
      r_ex_rd      <= '0;
      r_ex_is_load <= 1'b0;
      r_ex_illegal <= 1'b0;
    end else if (i_flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_adv) begin
      r_ex_valid <= w_xfer;
      if (w_xfer) begin
        r_a          <= w_op1;
        r_b          <= i_dec_alu_src ? i_dec_imm : w_op2;
        r_alu_op     <= w_alu_op;
        r_store_data <= w_op2;
        r_ex_rd      <= i_dec_rd;
        r_ex_is_load <= i_dec_is_load;
        r_ex_illegal <= w_illegal;
      end
    end
  end

  assign o_ex_valid      = r_ex_valid;
  assign o_a             = r_a;
  assign o_b             = r_b;
  assign o_alu_op        = r_alu_op;
  assign o_ex_store_data = r_store_data;
  assign o_ex_rd         = r_ex_rd;
  assign o_ex_is_load    = r_ex_is_load;
  assign o_ex_illegal    = r_ex_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; expectations follow ALU_ISSUE_FWD_EN.
module tb_alu_issue_stage;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              dec_valid;
  logic              dec_ready;
  logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0]   dec_rs1_data, dec_rs2_data, dec_imm;
  logic              dec_alu_src;
  logic [1:0]        dec_alu_class;
  logic [2:0]        dec_funct3;
  logic              dec_funct7_5;
  logic              dec_is_load;
  logic              flush;
  logic              mem_fwd_valid;
  logic [REG_AW-1:0] mem_fwd_rd;
  logic [XLEN-1:0]   mem_fwd_data;
  logic              wb_fwd_valid;
  logic [REG_AW-1:0] wb_fwd_rd;
  logic [XLEN-1:0]   wb_fwd_data;
  logic              ex_ready;
  logic              ex_valid;
  logic [XLEN-1:0]   a, b, ex_store_data;
  logic [3:0]        alu_op;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_is_load;
  logic              ex_illegal;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_dec_valid     (dec_valid),
    .o_dec_ready     (dec_ready),
    .i_dec_rs1       (dec_rs1),
    .i_dec_rs2       (dec_rs2),
    .i_dec_rd        (dec_rd),
    .i_dec_rs1_data  (dec_rs1_data),
    .i_dec_rs2_data  (dec_rs2_data),
    .i_dec_imm       (dec_imm),
    .i_dec_alu_src   (dec_alu_src),
    .i_dec_alu_class (dec_alu_class),
    .i_dec_funct3    (dec_funct3),
    .i_dec_funct7_5  (dec_funct7_5),
    .i_dec_is_load   (dec_is_load),
    .i_flush         (flush),
    .i_mem_fwd_valid (mem_fwd_valid),
    .i_mem_fwd_rd    (mem_fwd_rd),
    .i_mem_fwd_data  (mem_fwd_data),
    .i_wb_fwd_valid  (wb_fwd_valid),
    .i_wb_fwd_rd     (wb_fwd_rd),
    .i_wb_fwd_data   (wb_fwd_data),
    .i_ex_ready      (ex_ready),
    .o_ex_valid      (ex_valid),
    .o_a             (a),
    .o_b             (b),
    .o_alu_op        (alu_op),
    .o_ex_store_data (ex_store_data),
    .o_ex_rd         (ex_rd),
    .o_ex_is_load    (ex_is_load),
    .o_ex_illegal    (ex_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                      input logic src, input logic [1:0] cls, input logic [2:0] f3,
                      input logic f75, input logic ld);
    dec_valid     = 1'b1;
    dec_rs1       = rs1;
    dec_rs2       = rs2;
    dec_rd        = rd;
    dec_rs1_data  = d1;
    dec_rs2_data  = d2;
    dec_imm       = imm;
    dec_alu_src   = src;
    dec_alu_class = cls;
    dec_funct3    = f3;
    dec_funct7_5  = f75;
    dec_is_load   = ld;
  endtask

  task automatic fwd_off();
    mem_fwd_valid = 1'b0;
    mem_fwd_rd    = '0;
    mem_fwd_data  = '0;
    wb_fwd_valid  = 1'b0;
    wb_fwd_rd     = '0;
    wb_fwd_data   = '0;
  endtask

  // class, funct3, funct7_5, expected ALUOp, expected illegal
  logic [1:0] t_cls [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
  logic [2:0] t_f3  [9] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b000, 3'b010, 3'b001, 3'b001,
                            3'b101};
  logic       t_f75 [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [3:0] t_op  [9] = '{4'b0110, 4'b0010, 4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b0110,
                            4'b0010, 4'b0010};
  logic       t_ill [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    ex_ready = 1'b1;
    fwd_off();
    beat(5'd1, 5'd2, 5'd3, 64'd30, 64'd20, 64'd0, 1'b0, 2'b10, 3'b000, 1'b1, 1'b0);

    // Reset held with a valid beat pending
    tick();
    tick();
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_a", a, 64'd0);
    chk("rst_b", b, 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_store", ex_store_data, 64'd0);
    chk("rst_rd", 64'(ex_rd), 64'd0);
    chk("rst_is_load", 64'(ex_is_load), 64'd0);
    chk("rst_illegal", 64'(ex_illegal), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_dec_ready", 64'(dec_ready), 64'd1);

    // ALUOp decode table, back-to-back beats
    for (int i = 0; i < 9; i++) begin
      beat(5'd1, 5'd2, 5'(10 + i), 64'd30, 64'd20, 64'd0, 1'b0, t_cls[i], t_f3[i], t_f75[i],
           1'b0);
      tick();
      chk($sformatf("dec%0d_valid", i), 64'(ex_valid), 64'd1);
      chk($sformatf("dec%0d_a", i), a, 64'd30);
      chk($sformatf("dec%0d_b", i), b, 64'd20);
      chk($sformatf("dec%0d_op", i), 64'(alu_op), 64'(t_op[i]));
      chk($sformatf("dec%0d_ill", i), 64'(ex_illegal), 64'(t_ill[i]));
      chk($sformatf("dec%0d_rd", i), 64'(ex_rd), 64'(10 + i));
    end
    dec_valid = 1'b0;
    tick();
    chk("bubble_valid", 64'(ex_valid), 64'd0);

    // Forwarding priority / stall on pending writers
    beat(5'd5, 5'd6, 5'd20, 64'd1, 64'd2, 64'd0, 1'b0, 2'b10, 3'b000, 1'b0, 1'b0);
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 64'd100;
    wb_fwd_valid  = 1'b1; wb_fwd_rd  = 5'd5; wb_fwd_data  = 64'd7;
    #1;
`ifdef ALU_ISSUE_FWD_EN
    chk("fwd_ready", 64'(dec_ready), 64'd1);
    tick();
    chk("fwd_mem_wins", a, 64'd100);
`else
    chk("nofwd_stall_ready", 64'(dec_ready), 64'd0);
    tick();
    chk("nofwd_stall_v0", 64'(ex_valid), 64'd0);
    tick();
    chk("nofwd_stall_v1", 64'(ex_valid), 64'd0);
    fwd_off();
    #1;
    chk("nofwd_release_ready", 64'(dec_ready), 64'd1);
    tick();
    chk("nofwd_a_regfile", a, 64'd1);
`endif
    beat(5'd0, 5'd6, 5'd21, 64'd55, 64'd2, 64'd0, 1'b0, 2'b10, 3'b000, 1'b0, 1'b0);
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 64'd100;
    wb_fwd_valid  = 1'b0;
    tick();
    chk("x0_a_zero", a, 64'd0);
    fwd_off();
    beat(5'd8, 5'd9, 5'd22, 64'd3, 64'd4, 64'd15, 1'b1, 2'b11, 3'b000, 1'b0, 1'b0);
    tick();
    chk("imm_b", b, 64'd15);
    chk("imm_a", a, 64'd3);
    chk("imm_store", ex_store_data, 64'd4);
`ifdef ALU_ISSUE_FWD_EN
    beat(5'd8, 5'd6, 5'd23, 64'd3, 64'd2, 64'd0, 1'b0, 2'b10, 3'b000, 1'b0, 1'b0);
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd6; wb_fwd_data = 64'd77;
    tick();
    chk("fwd_wb_b", b, 64'd77);
    chk("fwd_wb_store", ex_store_data, 64'd77);
    fwd_off();
`endif
    dec_valid = 1'b0;
    tick();

    // Load-use on rs2
    beat(5'd1, 5'd2, 5'd7, 64'd11, 64'd12, 64'd0, 1'b0, 2'b00, 3'b011, 1'b0, 1'b1);
    tick();
    chk("ld_valid", 64'(ex_valid), 64'd1);
    chk("ld_is_load", 64'(ex_is_load), 64'd1);
    chk("ld_rd", 64'(ex_rd), 64'd7);
    beat(5'd1, 5'd7, 5'd24, 64'd40, 64'd41, 64'd0, 1'b0, 2'b10, 3'b000, 1'b0, 1'b0);
    #1;
    chk("lu_ready_low", 64'(dec_ready), 64'd0);
    tick();
    chk("lu_bubble", 64'(ex_valid), 64'd0);
    chk("lu_ready_high", 64'(dec_ready), 64'd1);
    tick();
    chk("lu_accept_valid", 64'(ex_valid), 64'd1);
    chk("lu_accept_a", a, 64'd40);
    chk("lu_accept_b", b, 64'd41);
    chk("lu_accept_ld", 64'(ex_is_load), 64'd0);

    // Downstream backpressure
    ex_ready = 1'b0;
    beat(5'd3, 5'd4, 5'd25, 64'd90, 64'd91, 64'd0, 1'b0, 2'b10, 3'b111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp%0d_ready", i), 64'(dec_ready), 64'd0);
      tick();
      chk($sformatf("bp%0d_a", i), a, 64'd40);
      chk($sformatf("bp%0d_op", i), 64'(alu_op), 64'd2);
      chk($sformatf("bp%0d_valid", i), 64'(ex_valid), 64'd1);
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(dec_ready), 64'd1);
    tick();
    chk("bp_next_a", a, 64'd90);
    chk("bp_next_op", 64'(alu_op), 64'd0);

    // Flush drops both the registered and incoming op
    beat(5'd3, 5'd4, 5'd26, 64'd5, 64'd6, 64'd0, 1'b0, 2'b10, 3'b000, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(dec_ready), 64'd1);
    tick();
    flush = 1'b0;
    chk("flush_valid", 64'(ex_valid), 64'd0);

    // Reset while stalled
    beat(5'd3, 5'd4, 5'd27, 64'd8, 64'd9, 64'd0, 1'b0, 2'b10, 3'b110, 1'b0, 1'b0);
    tick();
    chk("pre_stall_a", a, 64'd8);
    ex_ready = 1'b0;
    beat(5'd11, 5'd12, 5'd28, 64'd66, 64'd67, 64'd0, 1'b0, 2'b10, 3'b000, 1'b0, 1'b0);
    tick();
    chk("stall_hold_a", a, 64'd8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("stall_rst_valid", 64'(ex_valid), 64'd0);
    chk("stall_rst_a", a, 64'd0);
    chk("stall_rst_b", b, 64'd0);
    chk("stall_rst_op", 64'(alu_op), 64'd0);
    chk("stall_rst_rd", 64'(ex_rd), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
